// File: rtl/key_led_pkg.sv
// Shared mode type and constants for the key/LED controller.
// Defining LED_BREATH_EN inserts BREATH between BLINK and OFF.
package key_led_pkg;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned PWM_W  = 8;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF    = 2'd0,
      MODE_ON     = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_BREATH = 2'd3
   } mode_e;

   // Mode sequence advanced by each accepted press.
   function automatic mode_e mode_next(input mode_e cur);
      mode_e nxt;
      nxt = MODE_OFF;
      case (cur)
         MODE_OFF:   nxt = MODE_ON;
         MODE_ON:    nxt = MODE_BLINK;
`ifdef LED_BREATH_EN
         MODE_BLINK: nxt = MODE_BREATH;
`endif
         default:    nxt = MODE_OFF;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, stability counter and press pulse.
// A key already held when reset releases is ignored until it has been seen released.
module key_debounce #(
   parameter logic [19:0] DEB_MAX = 20'd999_999
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key,
   output logic key_flag
);

   localparam int unsigned CNT_W = 20;
   localparam logic [CNT_W-1:0] CNT_TOP = DEB_MAX - 20'd1;

   logic             sync0;
   logic             sync1;
   logic             key_prev;
   logic             deb;
   logic             deb_d1;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             stable;
   logic             accept;

   always_comb begin
      stable  = (sync1 == key_prev);
      cnt_nxt = '0;
      if (stable) begin
         cnt_nxt = (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);
      end
      accept  = stable && (cnt_nxt == CNT_TOP);
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         sync0    <= 1'b1;
         sync1    <= 1'b1;
         key_prev <= 1'b1;
         cnt      <= '0;
         deb      <= 1'b1;
         deb_d1   <= 1'b1;
         armed    <= 1'b0;
         key_flag <= 1'b0;
      end else begin
         sync0    <= key;
         sync1    <= sync0;
         key_prev <= sync1;
         cnt      <= cnt_nxt;
         deb_d1   <= deb;
         if (accept) begin
            deb <= sync1;
            if (sync1) begin
               armed <= 1'b1;
            end
         end
         key_flag <= armed & deb_d1 & ~deb;
      end
   end

endmodule

// File: rtl/key_led_ctrl.sv
// Multi-channel key-driven LED controller: OFF/ON/BLINK per channel with a shared blink tick.
// Defining LED_BREATH_EN adds a BREATH mode driven by a shared PWM counter and ramping duty.
module key_led_ctrl #(
   parameter int unsigned NUM_CH  = 2,
   parameter logic [24:0] CNT_MAX = 25'd24_999_999,
   parameter logic [19:0] DEB_MAX = 20'd999_999
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [NUM_CH-1:0] key,
   output logic [NUM_CH-1:0] led,
   output logic [NUM_CH-1:0] key_flag
);

   import key_led_pkg::*;

   localparam int unsigned TICK_W = 25;
   localparam logic [TICK_W-1:0] TICK_TOP = CNT_MAX - 25'd1;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_c;
   logic              blink_phase;
   logic [NUM_CH-1:0] led_nxt;

   assign tick_c = (tick_cnt == TICK_TOP);

   // Free-running tick and blink phase shared by every channel.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         tick_cnt    <= '0;
         blink_phase <= 1'b0;
      end else begin
         tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
         if (tick_c) begin
            blink_phase <= ~blink_phase;
         end
      end
   end

`ifdef LED_BREATH_EN
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty;
   logic             duty_down;

   // Triangle duty ramp, one step per tick, compared against a free-running PWM count.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         pwm_cnt   <= '0;
         duty      <= '0;
         duty_down <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         if (tick_c) begin
            if (duty_down) begin
               duty <= duty - PWM_W'(1);
               if (duty == PWM_W'(1)) begin
                  duty_down <= 1'b0;
               end
            end else begin
               duty <= duty + PWM_W'(1);
               if (duty == PWM_W'(254)) begin
                  duty_down <= 1'b1;
               end
            end
         end
      end
   end
`endif

   for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
      mode_e mode;
      logic  led_bit_c;

      key_debounce #(
         .DEB_MAX (DEB_MAX)
      ) u_deb (
         .sys_clk  (sys_clk),
         .sys_rst  (sys_rst),
         .key      (key[i]),
         .key_flag (key_flag[i])
      );

      always_ff @(posedge sys_clk or negedge sys_rst) begin
         if (!sys_rst) begin
            mode <= MODE_OFF;
         end else if (key_flag[i]) begin
            mode <= mode_next(mode);
         end
      end

      always_comb begin
         led_bit_c = 1'b0;
         case (mode)
            MODE_ON:     led_bit_c = 1'b1;
            MODE_BLINK:  led_bit_c = blink_phase;
`ifdef LED_BREATH_EN
            MODE_BREATH: led_bit_c = (pwm_cnt < duty);
`endif
            default:     led_bit_c = 1'b0;
         endcase
      end

      assign led_nxt[i] = led_bit_c;
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         led <= '0;
      end else begin
         led <= led_nxt;
      end
   end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with NUM_CH=2, CNT_MAX=25, DEB_MAX=5, 20 ns clock.
// Honours LED_BREATH_EN for the mode-wrap step.
module tb_key_led_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [1:0] key;
   logic [1:0] led;
   logic [1:0] key_flag;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;

   key_led_ctrl #(
      .NUM_CH  (2),
      .CNT_MAX (25'd25),
      .DEB_MAX (20'd5)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key      (key),
      .led      (led),
      .key_flag (key_flag)
   );

   always #10 sys_clk = ~sys_clk;

   // Edges seen since reset released; drives the blink-phase model.
   always @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) k <= 0;
      else          k <= k + 1;
   end

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected led for a BLINK channel: phase registered one cycle late.
   function automatic logic blink_exp();
      return 1'(((k - 1) / 25) % 2);
   endfunction

   task automatic press(input logic [1:0] mask);
      key = key & ~mask;
      repeat (12) cyc();
      key = key | mask;
      repeat (12) cyc();
   endtask

   initial begin
      int         pulses0;
      int         pulses1;
      int         fidx;
      int         lidx;
      int         n;
      logic       prev;
      logic [1:0] fval;
      logic [1:0] led10;

      sys_rst = 1'b0;
      key     = 2'b00;

      // Reset with keys pressed, then release while still pressed.
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("rst_led", 32'(led), 32'd0);
         check("rst_flag", 32'(key_flag), 32'd0);
      end
      sys_rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("post_rst_flag", 32'(key_flag), 32'd0);
         check("post_rst_led", 32'(led), 32'd0);
      end

      // Release both keys: no pulse on release.
      key = 2'b11;
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("release_flag", 32'(key_flag), 32'd0);
      end

      // Clean press on key[0].
      key     = 2'b10;
      pulses0 = 0;
      fidx    = 0;
      lidx    = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (key_flag[0]) begin
            pulses0++;
            fidx = i;
         end
         if (led[0] && lidx == 0) lidx = i;
         check("clean_flag1", 32'(key_flag[1]), 32'd0);
      end
      check("clean_pulses", 32'(pulses0), 32'd1);
      check("clean_flag_cycle", 32'(fidx), 32'd8);
      check("clean_led_cycle", 32'(lidx), 32'd10);
      key = 2'b11;
      for (int i = 0; i < 12; i++) begin
         cyc();
         check("clean_release_flag", 32'(key_flag), 32'd0);
         check("clean_led_on", 32'(led), 32'd1);
      end

      // Bouncing key[1]: toggles every 2 cycles, then held high.
      for (int t = 0; t < 12; t++) begin
         key[1] = 1'((t / 2) % 2);
         cyc();
         check("bounce_flag", 32'(key_flag[1]), 32'd0);
      end
      key[1] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc();
         check("bounce_flag_after", 32'(key_flag), 32'd0);
         check("bounce_led1", 32'(led[1]), 32'd0);
      end

      // Channel 0 ON -> BLINK; period and phase.
      press(2'b01);
      prev = led[0];
      n    = 0;
      while (led[0] == prev && n < 40) begin
         cyc();
         n++;
      end
      check("blink_first_toggle", 32'(n < 40), 32'd1);
      for (int r = 0; r < 2; r++) begin
         prev = led[0];
         n    = 0;
         while (led[0] == prev && n < 40) begin
            cyc();
            n++;
         end
         check("blink_period", 32'(n), 32'd25);
      end

      // Channel 1 OFF -> ON -> BLINK, must be in phase with channel 0.
      press(2'b10);
      press(2'b10);
      for (int i = 0; i < 60; i++) begin
         cyc();
         check("blink_led0", 32'(led[0]), 32'(blink_exp()));
         check("blink_led1", 32'(led[1]), 32'(blink_exp()));
      end

      // Third press on channel 0 leaves BLINK.
      press(2'b01);
`ifdef LED_BREATH_EN
      begin
         int hi_a;
         int hi_b;
         hi_a = 0;
         hi_b = 0;
         for (int i = 0; i < 256; i++) begin
            cyc();
            if (led[0]) hi_a++;
         end
         for (int i = 0; i < 256; i++) begin
            cyc();
            if (led[0]) hi_b++;
         end
         check("breath_duty_rises", 32'(hi_b > hi_a), 32'd1);
      end
      press(2'b01);
      press(2'b10);
      press(2'b10);
`else
      for (int i = 0; i < 60; i++) begin
         cyc();
         check("wrap_led0_off", 32'(led[0]), 32'd0);
         check("wrap_led1_blink", 32'(led[1]), 32'(blink_exp()));
      end
      press(2'b10);
`endif
      cyc();
      check("both_off", 32'(led), 32'd0);

      // Simultaneous press on both channels from OFF.
      key     = 2'b00;
      pulses0 = 0;
      pulses1 = 0;
      fidx    = 0;
      fval    = 2'b00;
      led10   = 2'b00;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (key_flag[0]) pulses0++;
         if (key_flag[1]) pulses1++;
         if (key_flag != 2'b00 && fidx == 0) begin
            fidx = i;
            fval = key_flag;
         end
         if (i == 10) led10 = led;
      end
      check("simul_flag_cycle", 32'(fidx), 32'd8);
      check("simul_flag_val", 32'(fval), 32'd3);
      check("simul_pulses0", 32'(pulses0), 32'd1);
      check("simul_pulses1", 32'(pulses1), 32'd1);
      check("simul_led_cycle10", 32'(led10), 32'd3);
      check("simul_led_held", 32'(led), 32'd3);

      // Reset mid-operation with keys still held.
      sys_rst = 1'b0;
      #1;
      check("async_rst_led", 32'(led), 32'd0);
      check("async_rst_flag", 32'(key_flag), 32'd0);
      repeat (3) cyc();
      sys_rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         check("held_after_rst_flag", 32'(key_flag), 32'd0);
         check("held_after_rst_led", 32'(led), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
